// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The optional misaligned-access error is controlled by DMEM_MISALIGN_ERR_EN.
package dmem_pkg;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

   // RV32I load/store funct3 codes; unlisted codes fall back to word access
   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/data and load extraction.
// Misalignment is always reported; the top decides whether it matters
// (DMEM_MISALIGN_ERR_EN).
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]        size,
   input  logic [1:0]        addr_lo,
   input  logic [WORD_W-1:0] wdata,
   input  logic [WORD_W-1:0] rword,
   output logic [3:0]        be,
   output logic [WORD_W-1:0] wdata_sh,
   output logic [WORD_W-1:0] rdata,
   output logic              misalign
);

   logic [BYTE_W-1:0] rbyte;
   logic [HALF_W-1:0] rhalf;

   // Half accesses use addr[1] only, so a misaligned half is truncated
   // down to its natural boundary; word accesses ignore addr[1:0].
   always_comb begin
      be       = 4'b1111;
      wdata_sh = wdata;
      rdata    = rword;
      misalign = 1'b0;
      rbyte    = rword[{addr_lo, 3'b000} +: BYTE_W];
      rhalf    = rword[{addr_lo[1], 4'b0000} +: HALF_W];
      case (size)
         SZ_B, SZ_BU: begin
            be       = 4'b0001 << addr_lo;
            wdata_sh = {4{wdata[BYTE_W-1:0]}};
            rdata    = size[2] ? {{(WORD_W-BYTE_W){1'b0}}, rbyte}
                               : {{(WORD_W-BYTE_W){rbyte[BYTE_W-1]}}, rbyte};
         end
         SZ_H, SZ_HU: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[HALF_W-1:0]}};
            rdata    = size[2] ? {{(WORD_W-HALF_W){1'b0}}, rhalf}
                               : {{(WORD_W-HALF_W){rhalf[HALF_W-1]}}, rhalf};
            misalign = addr_lo[0];
         end
         default: misalign = |addr_lo;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed response latency.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses with
// rsp_err; otherwise low address bits are truncated and rsp_err stays 0.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [2:0]       req_size,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef DMEM_MISALIGN_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   dmem_state_e      state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] mem [DEPTH_WORDS];
   logic [WIDTH-1:0] rdata_q;
   logic             err_q;

   logic [AW-1:0]    widx;
   logic             accept, rsp_hs, drop;
   logic [WIDTH-1:0] rword, ld_data, wdata_sh;
   logic [3:0]       be;
   logic             misalign;
   logic             unused_addr;

   assign widx        = req_addr[AW+1:2];
   assign unused_addr = ^req_addr[WIDTH-1:AW+2];
   assign req_ready   = (state == IDLE);
   assign rsp_valid   = (state == RESP);
   assign accept      = req_valid && req_ready;
   assign rsp_hs      = rsp_valid && rsp_ready;
   assign rword       = mem[widx];
   assign drop        = ERR_EN && misalign;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;

   dmem_lane_align u_align (
      .size     (req_size),
      .addr_lo  (req_addr[1:0]),
      .wdata    (req_wdata),
      .rword    (rword),
      .be       (be),
      .wdata_sh (wdata_sh),
      .rdata    (ld_data),
      .misalign (misalign)
   );

   // State and latency counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next state: WAIT counts LATENCY-2 down to 0 so RESP appears LATENCY
   // cycles after the accept cycle.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: if (accept) begin
            if (LATENCY == 1) begin
               state_nx = RESP;
            end else begin
               state_nx = WAIT;
               cnt_nx   = CW'(LATENCY - 2);
            end
         end
         WAIT: begin
            if (cnt == '0) state_nx = RESP;
            else           cnt_nx   = cnt - CW'(1);
         end
         RESP: if (rsp_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Storage commits stores on the accept edge; contents are never reset
   always_ff @(posedge clk) begin
      if (accept && req_we && !drop) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][i*BYTE_W +: BYTE_W] <= wdata_sh[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // Response captured at accept and held until the next accept
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         rdata_q <= (req_we || drop) ? '0 : ld_data;
         err_q   <= drop;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder with a byte-array model.
module tb_dmem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_size = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int tests = 0;
   int fails = 0;
   int rr_mode = 0;   // 0: always ready, 1: random, 2: stalled

   dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  mb [4096];
   bit          busy = 0;
   int          cyc = 0, acc_cyc = 0;
   logic [31:0] m_rd;
   logic        m_er;

   task automatic model_access(input logic we, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int n, off, base;
      logic [31:0] v;
      n    = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
      off  = int'(a & 32'hFFF);
      base = (off / n) * n;
      rd = 0;
      er = 0;
`ifdef DMEM_MISALIGN_ERR_EN
      if (off != base) begin
         er = 1;
         return;
      end
`endif
      if (we) begin
         for (int i = 0; i < n; i++) mb[base+i] = wd[8*i +: 8];
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v = v | (32'(mb[base+i]) << (8*i));
         if (n < 4 && !sz[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         rd = v;
      end
   endtask

   // Per-cycle compare against the model, then advance the model for the next edge
   always @(negedge clk) begin
      bit ev;
      if (!rst) begin
         busy = 0;
         chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
         chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
         chk("rst_rsp_rdata", rsp_rdata, 32'd0);
         chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      end else begin
         ev = busy && (cyc - acc_cyc >= LAT);
         chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
         chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
         if (ev) begin
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_er});
         end
         if (!busy && req_valid) begin
            model_access(req_we, req_addr, req_size, req_wdata, m_rd, m_er);
            busy    = 1;
            acc_cyc = cyc;
         end else if (ev && rsp_ready) begin
            busy = 0;
         end
      end
      cyc++;
   end

   // rsp_ready driver
   always @(posedge clk) begin
      #2;
      case (rr_mode)
         0:       rsp_ready = 1'b1;
         1:       rsp_ready = 1'($urandom_range(0, 1));
         default: rsp_ready = 1'b0;
      endcase
   end

   // One full transaction; entered and left just after a rising edge
   task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
      int n;
      req_valid = 1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 100);
      if (!req_ready) begin
         tests++; fails++;
         $display("FAIL accept_timeout: got req_ready 0 required 1");
      end
      @(posedge clk); #1 req_valid = 0;
      lat = -1; n = 0;
      do begin
         @(negedge clk); n++;
         if (rsp_valid && lat < 0) lat = n;
      end while (!(rsp_valid && rsp_ready) && n < 200);
      if (!(rsp_valid && rsp_ready)) begin
         tests++; fails++;
         $display("FAIL rsp_timeout: got no response, required one");
      end
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd, hold, r;
      logic        er;
      int          lat, n;

      repeat (3) @(posedge clk);
      #1 rst = 1;

      // fill storage so every later load has a defined expectation
      for (int w = 0; w < 1024; w++) xact(1, w * 4, 3'b010, $urandom, rd, er, lat);

      // 1: word store/load and latency
      xact(1, 32'h100, 3'b010, 32'hDEADBEEF, rd, er, lat);
      chk("t1_sw_lat", lat, LAT);
      chk("t1_sw_rdata", rd, 32'h0);
      xact(0, 32'h100, 3'b010, 0, rd, er, lat);
      chk("t1_lw", rd, 32'hDEADBEEF);
      chk("t1_lw_lat", lat, LAT);

      // 2: byte store, signed and unsigned byte loads
      xact(1, 32'h100, 3'b010, 32'h0, rd, er, lat);
      xact(1, 32'h101, 3'b000, 32'h80, rd, er, lat);
      xact(0, 32'h100, 3'b010, 0, rd, er, lat);
      chk("t2_word", rd, 32'h00008000);
      xact(0, 32'h101, 3'b000, 0, rd, er, lat);
      chk("t2_lb", rd, 32'hFFFFFF80);
      xact(0, 32'h101, 3'b100, 0, rd, er, lat);
      chk("t2_lbu", rd, 32'h00000080);

      // 3: halfword store to upper lanes
      xact(1, 32'h200, 3'b010, 32'h11223344, rd, er, lat);
      xact(1, 32'h202, 3'b001, 32'hABCD8001, rd, er, lat);
      xact(0, 32'h202, 3'b001, 0, rd, er, lat);
      chk("t3_lh", rd, 32'hFFFF8001);
      xact(0, 32'h202, 3'b101, 0, rd, er, lat);
      chk("t3_lhu", rd, 32'h00008001);
      xact(0, 32'h200, 3'b010, 0, rd, er, lat);
      chk("t3_word", rd, 32'h80013344);

      // 4: response back-pressure with a second request pending
      rr_mode = 2;
      @(posedge clk); #1;
      req_valid = 1; req_we = 0; req_addr = 32'h200; req_size = 3'b010;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 100);
      @(posedge clk); #1 req_addr = 32'h100;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
      hold = rsp_rdata;
      chk("t4_rdata", hold, 32'h80013344);
      repeat (5) begin
         @(negedge clk);
         chk("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("t4_hold_rdata", rsp_rdata, hold);
         chk("t4_hold_ready", {31'b0, req_ready}, 32'd0);
      end
      @(posedge clk); #1 req_valid = 0; rr_mode = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!(rsp_valid && rsp_ready) && n < 100);
      chk("t4_final_rdata", rsp_rdata, 32'h80013344);
      @(posedge clk); #1;

      // 5: reset during WAIT keeps the committed store
      req_valid = 1; req_we = 1; req_addr = 32'h10; req_size = 3'b010; req_wdata = 32'h12345678;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 100);
      @(posedge clk); #1 req_valid = 0;
      #1 rst = 0;
      #1;
      chk("t5_rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("t5_rst_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1 rst = 1;
      xact(0, 32'h10, 3'b010, 0, rd, er, lat);
      chk("t5_lw", rd, 32'h12345678);

      // 6: misaligned word load (word at 0x100 is 0x00008000)
      xact(0, 32'h102, 3'b010, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
      chk("t6_rdata", rd, 32'h0);
      chk("t6_err", {31'b0, er}, 32'd1);
`else
      chk("t6_rdata", rd, 32'h00008000);
      chk("t6_err", {31'b0, er}, 32'd0);
`endif

      // random traffic with random response back-pressure
      rr_mode = 1;
      for (int k = 0; k < 400; k++) begin
         r = $urandom;
         xact(1'($urandom_range(0, 1)), r & 32'hFFFF_F03F, 3'($urandom_range(0, 7)),
              $urandom, rd, er, lat);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      rr_mode = 0;
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port: accepts one load or store request at a time over a valid/ready handshake, performs the RV32I byte, halfword or word access on internal storage, and returns a response after a fixed latency. It is the target end of the load/store path, replacing the zero-latency data memory. The core stalls on `req_ready`/`rsp_valid`.

## Interface
Parameters:
- `WIDTH`, 32, data and address width.
- `DEPTH_WORDS`, 1024, number of 32-bit storage words; must be a power of two.
- `LATENCY`, 2, cycles from request acceptance to `rsp_valid`; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  WIDTH  byte address.
- `req_size`  in  3  RV32I funct3 of the load or store.
- `req_wdata`  in  WIDTH  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core accepts the response.
- `rsp_rdata`  out  WIDTH  load result, already extended; 0 for stores.
- `rsp_err`  out  1  misaligned access flag. Tied to 0 unless the macro is defined.

## Operation
- FSM states:
  - `IDLE`: `req_ready`=1.
  - `WAIT`: latency countdown.
  - `RESP`: `rsp_valid`=1.
- FSM transitions:
  - Accept when `req_valid && req_ready` → `WAIT`, or → `RESP` directly if `LATENCY`=1.
  - `WAIT` decrements its counter. At count 0 it moves to `RESP`.
  - `RESP` holds until `rsp_valid && rsp_ready`, then returns to `IDLE`.
- Only one request is outstanding at a time. Requests presented outside `IDLE` are ignored; the core must hold them.
- Word index is `req_addr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so the address space wraps.
- Byte lane is `req_addr[1:0]`. Data is little-endian.
- Store on accept edge:
  - `000` SB writes one byte lane.
  - `001` SH writes lanes {a1,0}+1:{a1,0}.
  - `010` SW writes the whole word.
  - Other lanes are unchanged.
- Load is sampled on the accept edge into a response register:
  - `000` LB sign-extends.
  - `100` LBU zero-extends.
  - `001` LH sign-extends.
  - `101` LHU zero-extends.
  - `010` LW returns the word.
- Codes `011`, `110` and `111` are treated as word access.
- Response data and error are registered and held stable while `rsp_valid`=1 and `rsp_ready`=0.
- Storage is not reset; contents survive `rst`.

## Timing
- Reset values: state `IDLE`, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Accept at edge T. `rsp_valid` rises after edge T+`LATENCY`-1, i.e. it is first visible `LATENCY` cycles after the accept cycle.
- Response handshake at edge R. `req_ready` is 1 in the cycle after R, so the minimum period is `LATENCY`+1 cycles per access.
- `req_ready` and `rsp_valid` are never 1 in the same cycle.
- Reset asserted mid-operation:
  - FSM aborts to `IDLE` immediately and the pending response is dropped.
  - A store accepted before reset stays committed.
- A load issued after a store to the same address sees the stored data, because the store commits at its accept edge.

## Configuration
- `DMEM_MISALIGN_ERR_EN` defined:
  - A misaligned halfword (`addr[0]`=1) or word (`addr[1:0]`≠0) access does not write storage.
  - The response returns `rsp_rdata`=0 and `rsp_err`=1 with normal latency.
- Not defined: misaligned low address bits are truncated to the access alignment, and `rsp_err` is constant 0.

## Structure
- `dmem_pkg` holds:
  - the `mem_size_e` enum for the funct3 codes;
  - the `dmem_state_e` enum (`IDLE`, `WAIT`, `RESP`);
  - byte/half/word width constants.
- Sub-module `dmem_lane_align` is purely combinational:
  - Store path: builds the per-lane write enables and shifted write data from size, `addr[1:0]` and `wdata`.
  - Load path: extracts and extends the load result from the read word.
- The top level holds the FSM, the latency counter, the storage array and the response registers.

## Test plan
1. Reset then SW `0xDEADBEEF` at `0x100`, then LW `0x100`.
   - `rsp_rdata`=`0xDEADBEEF`.
   - With `LATENCY`=2, `rsp_valid` is high 2 cycles after each accept.
2. SB `0x80` at `0x101` over word `0x00000000`, then LB `0x101` and LBU `0x101`.
   - Word becomes `0x00008000`.
   - LB returns `0xFFFFFF80`; LBU returns `0x00000080`.
3. SH `0x8001` at `0x202`, then LH `0x202` and LHU `0x202`.
   - LH returns `0xFFFF8001`; LHU returns `0x00008001`.
   - Lanes 0 and 1 are unchanged.
4. Hold `rsp_ready`=0 for 5 cycles during a load.
   - `rsp_valid` and `rsp_rdata` stay stable.
   - `req_ready`=0 throughout, and a second `req_valid` is not accepted.
5. Assert `rst` while in `WAIT` after a SW `0x12345678` to `0x10`.
   - `rsp_valid`=0 and `req_ready`=1 immediately.
   - A later LW `0x10` returns `0x12345678`.
6. LW at `0x102`.
   - With `DMEM_MISALIGN_ERR_EN`: `rsp_err`=1 and `rsp_rdata`=0.
   - Without it: returns the word at `0x100` with `rsp_err`=0.
